jtag_scan_ctrl: RTL

- System-clock-domain JTAG master that sequences the on-chip TAP controller.
- Generates tck/tms/tdi and captures tdo.
- Lets a host-side command port (CPU or test sequencer) run TAP reset, IR scans, DR scans and Run-Test/Idle cycles without bit-banging.
- Sits between the host interface and the TAP's tck/tms/tdi/tdo pins. The TAP is always left parked in Run-Test/Idle between commands.

---
 rtl/jtag_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_ctrl.sv
// JTAG master: sequences the TAP from the system clock domain.
// Runs TAP reset, IR/DR scans and idle cycles, then parks the TAP in Run-Test/Idle.
module jtag_scan_ctrl #(
    parameter int TCK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RESP
    } state_t;

    state_t             r_state, w_state, w_done;
    logic [1:0]         r_op, w_op;
    logic [5:0]         r_len, w_len, r_cnt, w_cnt;
    logic [5:0]         w_cmd_len, w_last;
    logic [MAX_LEN-1:0] r_data, w_data, r_cap, w_cap;
    logic [DW-1:0]      r_div, w_div;
    logic               r_tck, w_tck, r_tms, w_tms;
    logic               r_tdi, w_tdi, r_auto, w_auto;
    logic               w_tc, w_scan;

    // tms/tdi for bit cnt of the given phase; zero once parked
    function automatic logic [1:0] bit_out(
        input state_t             s,
        input logic [1:0]         op,
        input logic [5:0]         len,
        input logic [MAX_LEN-1:0] data,
        input logic [5:0]         cnt
    );
        logic b_tms, b_tdi;
        b_tms = 1'b0;
        b_tdi = 1'b0;
        case (s)
            S_HDR: begin
                if (op == OP_IR) b_tms = (cnt < 6'd2);
                else             b_tms = (cnt == 6'd0);
            end
            S_SHIFT: begin
                unique case (1'b1)
                    op == OP_RST:  b_tms = (cnt < 6'd6);
                    op == OP_IDLE: b_tms = 1'b0;
                    default: begin
                        b_tms = (cnt == len - 6'd1);
                        b_tdi = data[cnt[IW-1:0]];
                    end
                endcase
            end
            S_TRL:   b_tms = (cnt == 6'd0);
            default: b_tms = 1'b0;
        endcase
        return {b_tms, b_tdi};
    endfunction

    assign w_tc   = (r_div == DW'(TCK_DIV - 1));
    assign w_scan = (r_op == OP_IR) || (r_op == OP_DR);
    assign w_done = r_auto ? S_IDLE : S_RESP;

    always_comb begin
        if (cmd_len == 6'd0)                w_cmd_len = 6'd1;
        else if (cmd_len > 6'(MAX_LEN))     w_cmd_len = 6'(MAX_LEN);
        else                                w_cmd_len = cmd_len;
    end

    always_comb begin
        case (r_state)
            S_HDR:   w_last = (r_op == OP_IR) ? 6'd3 : 6'd2;
            S_SHIFT: w_last = (r_op == OP_RST) ? 6'd6 : r_len - 6'd1;
            default: w_last = 6'd1;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_op    = r_op;
        w_len   = r_len;
        w_data  = r_data;
        w_cap   = r_cap;
        w_cnt   = r_cnt;
        w_div   = r_div;
        w_tck   = r_tck;
        w_tms   = r_tms;
        w_tdi   = r_tdi;
        w_auto  = r_auto;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op   = cmd_op;
                    w_len  = w_cmd_len;
                    w_data = cmd_data;
                    w_cap  = '0;
                    w_cnt  = 6'd0;
                    w_div  = '0;
                    if (cmd_op == OP_IR || cmd_op == OP_DR)
                        w_state = S_HDR;
                    else
                        w_state = S_SHIFT;
                    {w_tms, w_tdi} = bit_out(w_state, cmd_op,
                                             w_cmd_len, cmd_data, 6'd0);
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state = S_IDLE;
            end
            default: begin
                w_div = w_tc ? '0 : r_div + DW'(1);
                if (w_tc) begin
                    w_tck = ~r_tck;
                    if (!r_tck) begin
                        // tdo still holds the value from before the TAP posedge
                        if (r_state == S_SHIFT && w_scan)
                            w_cap[r_cnt[IW-1:0]] = tdo;
                    end else begin
                        if (r_cnt == w_last) begin
                            w_cnt = 6'd0;
                            case (r_state)
                                S_HDR:   w_state = S_SHIFT;
                                S_SHIFT: w_state = w_scan ? S_TRL : w_done;
                                default: w_state = w_done;
                            endcase
                            if (w_state == w_done) w_auto = 1'b0;
                        end else begin
                            w_cnt = r_cnt + 6'd1;
                        end
                        {w_tms, w_tdi} = bit_out(w_state, r_op,
                                                 r_len, r_data, w_cnt);
                    end
                end
            end
        endcase
    end

    // reset lands directly in the TAP_RESET stream so the TAP is re-synced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SHIFT;
            r_op    <= OP_RST;
            r_auto  <= 1'b1;
            r_len   <= 6'd0;
            r_data  <= '0;
            r_cap   <= '0;
            r_cnt   <= 6'd0;
            r_div   <= '0;
            r_tck   <= 1'b0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_op    <= w_op;
            r_auto  <= w_auto;
            r_len   <= w_len;
            r_data  <= w_data;
            r_cap   <= w_cap;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_tck   <= w_tck;
            r_tms   <= w_tms;
            r_tdi   <= w_tdi;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state == S_HDR) || (r_state == S_SHIFT)
                    || (r_state == S_TRL);
    assign rsp_data  = r_cap;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

endmodule
